mul_unit: RTL



---
 rtl/mul_unit.sv | 100 ++++++++++
 1 files changed

// File: rtl/mul_unit.sv
// Sequential shift-add multiplier: latches operands on START, runs WIDTH iterations,
// then presents the registered 2*WIDTH-bit product with a one-cycle DONE pulse.
module mul_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] OPERAND1,
  input  logic [WIDTH-1:0] OPERAND2,
  input  logic             START,
  input  logic             SIGNEDOP,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic             OVERFLOW,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e               state_q;
  logic                 signed_q;
  logic                 neg_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CntW-1:0]      cnt_q;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     mag1;
  logic [WIDTH-1:0]     mag2;
  logic                 last;
  logic                 ovf_d;

  always_comb begin
    // Magnitudes; -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    mag1  = (SIGNEDOP && OPERAND1[WIDTH-1]) ? (~OPERAND1 + WIDTH'(1)) : OPERAND1;
    mag2  = (SIGNEDOP && OPERAND2[WIDTH-1]) ? (~OPERAND2 + WIDTH'(1)) : OPERAND2;
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_d = {sum, acc_q[WIDTH-1:1]};
    prod  = neg_q ? (~acc_d + (2*WIDTH)'(1)) : acc_d;
    ovf_d = signed_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                     : (prod[2*WIDTH-1:WIDTH] != '0);
    last  = (cnt_q == CntW'(WIDTH - 1));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      signed_q  <= 1'b0;
      neg_q     <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      RESULT    <= '0;
      RESULT_HI <= '0;
      OVERFLOW  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state_q)
        StIdle, StFin: begin
          if (START) begin
            state_q  <= StRun;
            signed_q <= SIGNEDOP;
            neg_q    <= SIGNEDOP & (OPERAND1[WIDTH-1] ^ OPERAND2[WIDTH-1]);
            mcand_q  <= mag1;
            mplier_q <= mag2;
            acc_q    <= '0;
            cnt_q    <= '0;
            BUSY     <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CntW'(1);
          if (last) begin
            state_q   <= StFin;
            RESULT    <= prod[WIDTH-1:0];
            RESULT_HI <= prod[2*WIDTH-1:WIDTH];
            OVERFLOW  <= ovf_d;
            BUSY      <= 1'b0;
            DONE      <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
